// File: rtl/lsq_pkg.sv
// Shared types for the load/store queue: entry payload and issue FSM states.
package lsq_pkg;

  localparam int unsigned LSQ_PC_W   = 12;
  localparam int unsigned LSQ_ADDR_W = 32;
  localparam int unsigned LSQ_DATA_W = 32;

  typedef struct packed {
    logic                  is_load;
    logic [LSQ_PC_W-1:0]   pc;
    logic [LSQ_ADDR_W-1:0] addr;
    logic [LSQ_DATA_W-1:0] data;
    logic                  valid;
    logic                  addr_valid;
    logic                  committed;
  } lsq_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DRAIN    = 2'd3
  } lsq_state_e;

endpackage

// File: rtl/lsq_ptr.sv
// Wrap pointer: index bits plus a wrap MSB; load takes priority over increment.
module lsq_ptr #(
  parameter int unsigned PTR_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             load,
  input  logic [PTR_W-1:0] load_val,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/lsq_ring.sv
// Circular load/store queue: in-order alloc, out-of-order execute writeback,
// in-order memory issue from the head with one outstanding transaction.
module lsq_ring
  import lsq_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned PC_WIDTH    = 12,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES),
  localparam int unsigned PTR_W      = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic                  alloc_is_load,
  input  logic [PC_WIDTH-1:0]   alloc_pc,
  output logic [IDX_W-1:0]      alloc_idx,
  input  logic                  ex_valid,
  input  logic [IDX_W-1:0]      ex_idx,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_data,
  input  logic                  commit_valid,
  input  logic [IDX_W-1:0]      commit_idx,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  ld_wb_valid,
  output logic [IDX_W-1:0]      ld_wb_idx,
  output logic [PC_WIDTH-1:0]   ld_wb_pc,
  output logic [DATA_WIDTH-1:0] ld_wb_data,
  output logic [PTR_W-1:0]      count
);

  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W-1:0] tail_flush;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             full, alloc_fire, retire;

  lsq_entry_t entries_q [NUM_ENTRIES];
  lsq_entry_t entries_d [NUM_ENTRIES];
  lsq_entry_t head_e;

  lsq_state_e            state_q, state_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  mem_req_we_q, mem_req_we_d;
  logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [DATA_WIDTH-1:0] mem_req_wdata_q, mem_req_wdata_d;
  logic                  ld_wb_valid_q, ld_wb_valid_d;
  logic [IDX_W-1:0]      ld_wb_idx_q, ld_wb_idx_d;
  logic [PC_WIDTH-1:0]   ld_wb_pc_q, ld_wb_pc_d;
  logic [DATA_WIDTH-1:0] ld_wb_data_q, ld_wb_data_d;

  logic head_elig, head_commit_eff, kill_head;

  lsq_ptr #(.PTR_W(PTR_W)) u_head (
    .clk      (clk),
    .reset    (reset),
    .inc      (retire),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (head_q)
  );

  lsq_ptr #(.PTR_W(PTR_W)) u_tail (
    .clk      (clk),
    .reset    (reset),
    .inc      (alloc_fire),
    .load     (flush),
    .load_val (tail_flush),
    .ptr      (tail_q)
  );

  assign head_idx    = head_q[IDX_W-1:0];
  assign tail_idx    = tail_q[IDX_W-1:0];
  assign full        = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign alloc_ready = !full && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_idx   = tail_idx;
  assign count       = tail_q - head_q;
  assign head_e      = entries_q[head_idx];

  assign head_elig = head_e.valid && head_e.addr_valid && (head_e.is_load || head_e.committed);
  // A commit landing in the flush cycle still protects the head entry.
  assign head_commit_eff = head_e.committed ||
                           (commit_valid && (commit_idx == head_idx) && head_e.valid);
  assign kill_head = flush && !head_commit_eff;

  // Issue FSM: one memory transaction at a time, always for the head entry.
  always_comb begin
    state_d         = state_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_we_d    = mem_req_we_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;
    ld_wb_valid_d   = 1'b0;
    ld_wb_idx_d     = ld_wb_idx_q;
    ld_wb_pc_d      = ld_wb_pc_q;
    ld_wb_data_d    = ld_wb_data_q;
    retire          = 1'b0;

    case (state_q)
      IDLE: begin
        if (head_elig && !kill_head) begin
          mem_req_valid_d = 1'b1;
          mem_req_we_d    = !head_e.is_load;
          mem_req_addr_d  = ADDR_WIDTH'(head_e.addr);
          mem_req_wdata_d = head_e.is_load ? '0 : DATA_WIDTH'(head_e.data);
          state_d         = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          if (mem_req_we_q) begin
            retire  = 1'b1;
            state_d = IDLE;
          end else if (kill_head) begin
            state_d = DRAIN;
          end else begin
            state_d = WAIT_RSP;
          end
        end else if (kill_head && !mem_req_we_q) begin
          mem_req_valid_d = 1'b0;
          state_d         = IDLE;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
          // A response racing a flush of its uncommitted load is simply dropped.
          if (!kill_head) begin
            ld_wb_valid_d = 1'b1;
            ld_wb_idx_d   = head_idx;
            ld_wb_pc_d    = PC_WIDTH'(head_e.pc);
            ld_wb_data_d  = mem_rsp_data;
            retire        = 1'b1;
          end
        end else if (kill_head) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry updates, applied in order: alloc, execute, commit, retire, flush.
  always_comb begin
    logic [PTR_W-1:0] keep_cnt;
    keep_cnt = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      entries_d[IDX_W'(i)] = entries_q[IDX_W'(i)];
    end

    if (alloc_fire) begin
      entries_d[tail_idx].is_load    = alloc_is_load;
      entries_d[tail_idx].pc         = LSQ_PC_W'(alloc_pc);
      entries_d[tail_idx].valid      = 1'b1;
      entries_d[tail_idx].addr_valid = 1'b0;
      entries_d[tail_idx].committed  = 1'b0;
    end

    if (ex_valid && entries_q[ex_idx].valid && !(retire && (ex_idx == head_idx))) begin
      entries_d[ex_idx].addr       = LSQ_ADDR_W'(ex_addr);
      entries_d[ex_idx].data       = LSQ_DATA_W'(ex_data);
      entries_d[ex_idx].addr_valid = 1'b1;
    end

    if (commit_valid && entries_q[commit_idx].valid) begin
      entries_d[commit_idx].committed = 1'b1;
    end

    if (retire) begin
      entries_d[head_idx].valid      = 1'b0;
      entries_d[head_idx].addr_valid = 1'b0;
      entries_d[head_idx].committed  = 1'b0;
    end

    if (flush) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (!entries_d[IDX_W'(i)].committed) begin
          entries_d[IDX_W'(i)].valid = 1'b0;
        end
        keep_cnt = keep_cnt +
                   PTR_W'(entries_d[IDX_W'(i)].valid & entries_d[IDX_W'(i)].committed);
      end
    end

    // Committed survivors are a contiguous prefix from the post-retire head.
    tail_flush = head_q + PTR_W'(retire) + keep_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        entries_q[IDX_W'(i)] <= '0;
      end
      state_q         <= IDLE;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      ld_wb_valid_q   <= 1'b0;
      ld_wb_idx_q     <= '0;
      ld_wb_pc_q      <= '0;
      ld_wb_data_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        entries_q[IDX_W'(i)] <= entries_d[IDX_W'(i)];
      end
      state_q         <= state_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      ld_wb_valid_q   <= ld_wb_valid_d;
      ld_wb_idx_q     <= ld_wb_idx_d;
      ld_wb_pc_q      <= ld_wb_pc_d;
      ld_wb_data_q    <= ld_wb_data_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we    = mem_req_we_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign ld_wb_valid   = ld_wb_valid_q;
  assign ld_wb_idx     = ld_wb_idx_q;
  assign ld_wb_pc      = ld_wb_pc_q;
  assign ld_wb_data    = ld_wb_data_q;

endmodule

// File: tb/tb_lsq_ring.sv
// Directed bench for lsq_ring: reset, store/load round trips, wrap, flush cases.
module tb_lsq_ring;

  localparam int unsigned N     = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned PCW   = 12;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             alloc_valid, alloc_ready, alloc_is_load;
  logic [PCW-1:0]   alloc_pc;
  logic [IDX_W-1:0] alloc_idx;
  logic             ex_valid;
  logic [IDX_W-1:0] ex_idx;
  logic [AW-1:0]    ex_addr;
  logic [DW-1:0]    ex_data;
  logic             commit_valid;
  logic [IDX_W-1:0] commit_idx;
  logic             flush;
  logic             mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0]    mem_req_addr;
  logic [DW-1:0]    mem_req_wdata;
  logic             mem_rsp_valid;
  logic [DW-1:0]    mem_rsp_data;
  logic             ld_wb_valid;
  logic [IDX_W-1:0] ld_wb_idx;
  logic [PCW-1:0]   ld_wb_pc;
  logic [DW-1:0]    ld_wb_data;
  logic [IDX_W:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  lsq_ring #(
    .NUM_ENTRIES (N),
    .PC_WIDTH    (PCW),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_is_load (alloc_is_load),
    .alloc_pc      (alloc_pc),
    .alloc_idx     (alloc_idx),
    .ex_valid      (ex_valid),
    .ex_idx        (ex_idx),
    .ex_addr       (ex_addr),
    .ex_data       (ex_data),
    .commit_valid  (commit_valid),
    .commit_idx    (commit_idx),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .ld_wb_valid   (ld_wb_valid),
    .ld_wb_idx     (ld_wb_idx),
    .ld_wb_pc      (ld_wb_pc),
    .ld_wb_data    (ld_wb_data),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic alloc(input logic ld, input logic [PCW-1:0] pc, input logic [IDX_W-1:0] exp_idx);
    alloc_valid   = 1'b1;
    alloc_is_load = ld;
    alloc_pc      = pc;
    #1;
    chk("alloc_ready", alloc_ready, 1);
    chk("alloc_idx", alloc_idx, exp_idx);
    cyc();
    alloc_valid = 1'b0;
  endtask

  task automatic ex_wr(input logic [IDX_W-1:0] idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ex_valid = 1'b1;
    ex_idx   = idx;
    ex_addr  = a;
    ex_data  = d;
    cyc();
    ex_valid = 1'b0;
  endtask

  task automatic commit(input logic [IDX_W-1:0] idx);
    commit_valid = 1'b1;
    commit_idx   = idx;
    cyc();
    commit_valid = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!mem_req_valid && n < budget) begin
      cyc();
      n++;
    end
    chk("req_seen", mem_req_valid, 1);
  endtask

  initial begin
    reset = 1'b1;
    alloc_valid = 0; alloc_is_load = 0; alloc_pc = '0;
    ex_valid = 0; ex_idx = '0; ex_addr = '0; ex_data = '0;
    commit_valid = 0; commit_idx = '0; flush = 0;
    mem_req_ready = 1'b1; mem_rsp_valid = 0; mem_rsp_data = '0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_idx", alloc_idx, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_ld_wb", ld_wb_valid, 0);

    // 1: reset while a load waits for its response; late response ignored
    alloc(1'b1, 12'h004, 4'd0);
    ex_wr(4'd0, 32'h10, 32'h0);
    wait_req(8);
    chk("t1_req_we", mem_req_we, 0);
    cyc();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    chk("t1_count", count, 0);
    chk("t1_req_valid", mem_req_valid, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1234;
    cyc();
    mem_rsp_valid = 1'b0;
    chk("t1_ld_wb_a", ld_wb_valid, 0);
    cyc();
    chk("t1_ld_wb_b", ld_wb_valid, 0);
    chk("t1_count2", count, 0);
    chk("t1_alloc_ready", alloc_ready, 1);

    // 2: fill with 16 stores, drain the committed head
    for (int i = 0; i < 16; i++) alloc(1'b0, PCW'(i), IDX_W'(i));
    alloc_valid = 1'b1;
    #1;
    chk("t2_full_ready", alloc_ready, 0);
    chk("t2_full_count", count, 16);
    cyc();
    alloc_valid = 1'b0;
    chk("t2_refused", count, 16);
    ex_wr(4'd0, 32'h100, 32'hAB);
    commit(4'd0);
    chk("t2_req_early", mem_req_valid, 0);
    cyc();
    chk("t2_req_valid", mem_req_valid, 1);
    chk("t2_req_we", mem_req_we, 1);
    chk("t2_req_addr", mem_req_addr, 32'h100);
    chk("t2_req_wdata", mem_req_wdata, 32'hAB);
    cyc();
    chk("t2_count", count, 15);
    chk("t2_req_drop", mem_req_valid, 0);
    flush = 1'b1;
    #1;
    chk("t2_flush_ready", alloc_ready, 0);
    cyc();
    flush = 1'b0;
    chk("t2_flush_count", count, 0);

    // 3: load round trip
    do_reset();
    alloc(1'b1, 12'h004, 4'd0);
    ex_wr(4'd0, 32'h200, 32'h0);
    wait_req(8);
    chk("t3_req_we", mem_req_we, 0);
    chk("t3_req_addr", mem_req_addr, 32'h200);
    repeat (3) cyc();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEADBEEF;
    cyc();
    mem_rsp_valid = 1'b0;
    chk("t3_wb_valid", ld_wb_valid, 1);
    chk("t3_wb_idx", ld_wb_idx, 0);
    chk("t3_wb_pc", ld_wb_pc, 12'h004);
    chk("t3_wb_data", ld_wb_data, 32'hDEADBEEF);
    chk("t3_count", count, 0);
    cyc();
    chk("t3_wb_pulse", ld_wb_valid, 0);

    // 4: 40 store alloc/retire pairs wrapping the ring (head starts at 1)
    for (int i = 0; i < 40; i++) begin
      alloc(1'b0, PCW'(i), IDX_W'((1 + i) % 16));
      ex_valid     = 1'b1;
      ex_idx       = IDX_W'((1 + i) % 16);
      ex_addr      = 32'h1000 + 32'(i) * 4;
      ex_data      = 32'hA5000000 | 32'(i);
      commit_valid = 1'b1;
      commit_idx   = IDX_W'((1 + i) % 16);
      cyc();
      ex_valid = 1'b0;
      commit_valid = 1'b0;
      wait_req(8);
      chk("t4_we", mem_req_we, 1);
      chk("t4_addr", mem_req_addr, 32'h1000 + 32'(i) * 4);
      chk("t4_wdata", mem_req_wdata, 32'hA5000000 | 32'(i));
      cyc();
      chk("t4_count", count, 0);
    end

    // 5: flush keeps the two committed stores at the head (head index 9)
    alloc(1'b0, 12'h050, 4'd9);
    alloc(1'b0, 12'h051, 4'd10);
    alloc(1'b1, 12'h052, 4'd11);
    alloc(1'b0, 12'h053, 4'd12);
    chk("t5_count4", count, 4);
    commit(4'd9);
    commit(4'd10);
    chk("t5_no_req", mem_req_valid, 0);
    flush = 1'b1;
    #1;
    chk("t5_flush_ready", alloc_ready, 0);
    cyc();
    flush = 1'b0;
    chk("t5_count", count, 2);
    chk("t5_next_idx", alloc_idx, 11);
    ex_wr(4'd9, 32'h900, 32'h9);
    ex_wr(4'd10, 32'hA00, 32'hA);
    wait_req(8);
    chk("t5_addr0", mem_req_addr, 32'h900);
    chk("t5_wdata0", mem_req_wdata, 32'h9);
    cyc();
    wait_req(8);
    chk("t5_addr1", mem_req_addr, 32'hA00);
    chk("t5_wdata1", mem_req_wdata, 32'hA);
    cyc();
    chk("t5_empty", count, 0);

    // 6: flush during WAIT_RSP drains the response silently
    alloc(1'b1, 12'h030, 4'd11);
    ex_wr(4'd11, 32'h300, 32'h0);
    wait_req(8);
    chk("t6_req_we", mem_req_we, 0);
    chk("t6_req_addr", mem_req_addr, 32'h300);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t6_count", count, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h55;
    cyc();
    mem_rsp_valid = 1'b0;
    chk("t6_no_wb_a", ld_wb_valid, 0);
    cyc();
    chk("t6_no_wb_b", ld_wb_valid, 0);
    alloc(1'b1, 12'h034, 4'd11);
    ex_wr(4'd11, 32'h340, 32'h0);
    wait_req(8);
    chk("t6_idle_addr", mem_req_addr, 32'h340);
    cyc();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFEF00D;
    cyc();
    mem_rsp_valid = 1'b0;
    chk("t6_wb_valid", ld_wb_valid, 1);
    chk("t6_wb_idx", ld_wb_idx, 11);
    chk("t6_wb_pc", ld_wb_pc, 12'h034);
    chk("t6_wb_data", ld_wb_data, 32'hCAFEF00D);
    chk("t6_count_end", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsq_ring.md
Name: lsq_ring

Overview:
Parametrised circular load/store queue sitting between rename/dispatch, the AGU writeback, the ROB commit port and the data-memory port.
- Entries allocate in program order at the tail.
- Address and data arrive out of order by index.
- Stores drain to memory only once committed; loads issue in order from the head.
- Flush discards every uncommitted entry.

Parameters:
- NUM_ENTRIES, 16, queue depth; power of two, ≥2.
- PC_WIDTH, 12, width of stored pc.
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, load/store data width.
- (derived, localparam) IDX_W = $clog2(NUM_ENTRIES); pointers are IDX_W+1 bits, the MSB being the wrap bit.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- alloc_valid  in  1  dispatch requests an entry
- alloc_ready  out  1  entry available (!full && !flush)
- alloc_is_load  in  1  1 = load, 0 = store
- alloc_pc  in  PC_WIDTH  instruction pc
- alloc_idx  out  IDX_W  index granted (= tail index), valid during handshake
- ex_valid  in  1  address/data writeback
- ex_idx  in  IDX_W  target entry
- ex_addr  in  ADDR_WIDTH  computed address
- ex_data  in  DATA_WIDTH  store data (ignored for loads)
- commit_valid  in  1  ROB commits an entry
- commit_idx  in  IDX_W  committed entry
- flush  in  1  discard uncommitted entries
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts
- mem_req_we  out  1  1 = store
- mem_req_addr  out  ADDR_WIDTH  request address
- mem_req_wdata  out  DATA_WIDTH  store data
- mem_rsp_valid  in  1  load data return
- mem_rsp_data  in  DATA_WIDTH  load data
- ld_wb_valid  out  1  load result pulse
- ld_wb_idx  out  IDX_W  completing entry
- ld_wb_pc  out  PC_WIDTH  its pc
- ld_wb_data  out  DATA_WIDTH  its data
- count  out  IDX_W+1  occupied entries

Behaviour:
Reset:
- Pointers zero; all valid, addr_valid and committed bits cleared; FSM IDLE.
- mem_req_valid=0, ld_wb_valid=0, count=0, alloc_ready=1; all data outputs 0.
- Any mem_rsp_valid arriving after reset, while not in WAIT_RSP, is ignored.

Full/empty:
- full = index bits equal and wrap bits differ; empty = pointers equal.
- count = tail − head, modulo 2^(IDX_W+1).

Allocate (alloc_valid && alloc_ready):
- Write is_load and pc at the tail; set valid; clear addr_valid and committed.
- Advance the tail. Alloc-to-visible latency is 1 cycle.

Execute writeback:
- ex_valid writes addr/data and sets addr_valid for entry ex_idx.
- Ignored if that entry is invalid.

Commit:
- commit_valid sets committed on a valid entry.
- The ROB commits in program order, so committed entries always form a prefix from the head.

Head eligibility: valid && addr_valid && (is_load || committed).

FSM:
- IDLE: if head is eligible, register the request, go to REQ.
- REQ: hold mem_req_* stable until mem_req_ready.
  - On accept of a store: retire head, go to IDLE.
  - On accept of a load: go to WAIT_RSP.
- WAIT_RSP: on mem_rsp_valid, next cycle ld_wb_valid=1 with idx/pc/data for one cycle; retire head; go to IDLE.
- DRAIN: wait for mem_rsp_valid, discard the data, go to IDLE.
- Maximum of one outstanding memory transaction.
- Earliest retire is 2 cycles after the head becomes eligible, with mem_req_ready tied high.

Flush:
- tail ← head + (number of committed valid entries); discarded entries have valid cleared.
- alloc_ready is low in the flush cycle.
- An uncommitted load in REQ without acceptance withdraws mem_req_valid (the only permitted withdrawal).
- An uncommitted load in REQ accepted in the flush cycle, or already in WAIT_RSP, goes to DRAIN with no ld_wb.
- Committed stores in flight are unaffected.

Simultaneous events:
- commit and flush in the same cycle: commit applies first, so the entry survives.
- retire and flush in the same cycle: retire applies, and the tail is computed from the new head.
- alloc and retire in the same cycle on a full queue: alloc is refused (alloc_ready reflects registered full).
- ex_valid targeting an entry being retired is ignored.

Wrap-around: pointer index bits wrap naturally; the wrap bit toggles.

Decomposition:
- lsq_pkg holds:
  - lsq_entry_t (is_load, pc, address, data, valid, addr_valid, committed), parametrised widths via package constants;
  - lsq_state_e (IDLE, REQ, WAIT_RSP, DRAIN).
- One sub-module, lsq_ptr: an (IDX_W+1)-bit wrap pointer with increment and load ports, instanced for head and tail.

Test Plan:
1. Reset mid-WAIT_RSP, then mem_rsp_valid=1 → no ld_wb_valid; count=0; alloc_ready=1.
2. Store round trip: allocate 16 stores (alloc_idx 0..15), check alloc_ready=0 at count=16; ex writes idx0 addr 0x100 data 0xAB; commit idx0 → mem_req we=1 addr 0x100 wdata 0xAB two cycles later; count=15.
3. Load round trip: allocate load pc 0x04, ex addr 0x200; mem_req_ready=1; mem_rsp data 0xDEADBEEF after 3 cycles → ld_wb_valid one cycle with idx0, pc 0x04, data 0xDEADBEEF.
4. Wrap-around: 40 alloc/retire pairs → indices wrap 15→0, count never exceeds 16, data stays correct.
5. Flush with commits: queue holds st(committed), st(committed), ld, st; flush → count=2, tail=head+2; the next alloc gets index head+2.
6. Flush during WAIT_RSP on an uncommitted load: flush → DRAIN; the response is dropped with no ld_wb_valid; FSM returns to IDLE; count=0.
